// File: rtl/tswitch_pkg.sv
// Shared switch-wide widths for the memory write path and request tagging.
package tswitch_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 8;
endpackage

// File: rtl/mc_write_engine.sv
// Multicast write engine: fans one accepted request out to every member port,
// gathers per-port write acks, and reports completion or timeout abort.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a request; latches it on valid&ready
// ISSUE    | drives mem_wr_valid for ports still awaiting their handshake
// WAIT_ACK | all writes issued; collecting the remaining acks
// DONE     | one-cycle mc_done pulse (mc_error set on timeout abort)
module mc_write_engine
  import tswitch_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_BITS      = $clog2(NUM_PORTS),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mc_req_valid,
  output logic                  mc_req_ready,
  input  logic [NUM_PORTS-1:0]  mc_req_mask,
  input  logic [ADDR_WIDTH-1:0] mc_req_addr,
  input  logic [DATA_WIDTH-1:0] mc_req_data,
  input  logic [TAG_WIDTH-1:0]  mc_req_tag,
  input  logic [PORT_BITS-1:0]  mc_req_src_port,
  output logic [NUM_PORTS-1:0]  mem_wr_valid,
  input  logic [NUM_PORTS-1:0]  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [NUM_PORTS-1:0]  mem_wr_ack,
  output logic                  mc_done,
  output logic [TAG_WIDTH-1:0]  mc_done_tag,
  output logic [PORT_BITS-1:0]  mc_done_src_port,
  output logic                  mc_error,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [PORT_BITS-1:0]  src_q;
  logic [NUM_PORTS-1:0]  issue_pend, issue_nxt;
  logic [NUM_PORTS-1:0]  ack_pend, ack_nxt;
  logic [NUM_PORTS-1:0]  hs, ack_acc;
  logic [CNT_W-1:0]      to_cnt, to_nxt;
  logic                  err_q, err_nxt;
  logic                  accept, progress, timeout;

  assign mc_req_ready     = (state == IDLE);
  assign busy             = (state != IDLE);
  assign mem_wr_valid     = (state == ISSUE) ? issue_pend : '0;
  assign mc_done          = (state == DONE);
  assign mc_error         = (state == DONE) && err_q;
  assign mem_wr_addr      = addr_q;
  assign mem_wr_data      = data_q;
  assign mc_done_tag      = tag_q;
  assign mc_done_src_port = src_q;

  always_comb begin
    state_nxt = state;
    issue_nxt = issue_pend;
    ack_nxt   = ack_pend;
    to_nxt    = to_cnt;
    err_nxt   = err_q;
    hs        = '0;
    ack_acc   = '0;
    accept    = 1'b0;
    progress  = 1'b0;
    timeout   = 1'b0;

    case (state)
      IDLE: begin
        accept = mc_req_valid;
        if (accept) begin
          issue_nxt = mc_req_mask;
          ack_nxt   = mc_req_mask;
          to_nxt    = '0;
          err_nxt   = 1'b0;
          state_nxt = (mc_req_mask == '0) ? DONE : ISSUE;
        end
      end

      ISSUE, WAIT_ACK: begin
        hs        = mem_wr_valid & mem_wr_ready;
        // An ack only counts once that port's write was handshaken in an earlier cycle.
        ack_acc   = mem_wr_ack & ack_pend & ~issue_pend;
        issue_nxt = issue_pend & ~hs;
        ack_nxt   = ack_pend & ~ack_acc;
        progress  = (hs != '0) || (ack_acc != '0);
        to_nxt    = progress ? '0 : to_cnt + CNT_W'(1);
        timeout   = !progress && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

        if (ack_nxt == '0) begin
          state_nxt = DONE;
          err_nxt   = 1'b0;
        end else if (timeout) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
          issue_nxt = '0;
          ack_nxt   = '0;
        end else if (state == ISSUE && issue_nxt == '0) begin
          state_nxt = WAIT_ACK;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      src_q      <= '0;
      issue_pend <= '0;
      ack_pend   <= '0;
      to_cnt     <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      issue_pend <= issue_nxt;
      ack_pend   <= ack_nxt;
      to_cnt     <= to_nxt;
      err_q      <= err_nxt;
      if (accept) begin
        addr_q <= mc_req_addr;
        data_q <= mc_req_data;
        tag_q  <= mc_req_tag;
        src_q  <= mc_req_src_port;
      end
    end
  end

endmodule

// File: tb/tb_mc_write_engine.sv
// Directed bench for mc_write_engine; completions are scoreboarded through a
// queue of expected {tag, src, error} entries pushed when each request is sent.
module tb_mc_write_engine;
  import tswitch_pkg::*;

  localparam int NP = 4;
  localparam int PB = 2;
  localparam int TO = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  mc_req_valid;
  logic                  mc_req_ready;
  logic [NP-1:0]         mc_req_mask;
  logic [ADDR_WIDTH-1:0] mc_req_addr;
  logic [DATA_WIDTH-1:0] mc_req_data;
  logic [TAG_WIDTH-1:0]  mc_req_tag;
  logic [PB-1:0]         mc_req_src_port;
  logic [NP-1:0]         mem_wr_valid;
  logic [NP-1:0]         mem_wr_ready;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [NP-1:0]         mem_wr_ack;
  logic                  mc_done;
  logic [TAG_WIDTH-1:0]  mc_done_tag;
  logic [PB-1:0]         mc_done_src_port;
  logic                  mc_error;
  logic                  busy;

  mc_write_engine #(.NUM_PORTS(NP), .PORT_BITS(PB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mc_req_valid(mc_req_valid), .mc_req_ready(mc_req_ready),
    .mc_req_mask(mc_req_mask), .mc_req_addr(mc_req_addr),
    .mc_req_data(mc_req_data), .mc_req_tag(mc_req_tag),
    .mc_req_src_port(mc_req_src_port),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack),
    .mc_done(mc_done), .mc_done_tag(mc_done_tag),
    .mc_done_src_port(mc_done_src_port), .mc_error(mc_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [PB-1:0]        src;
    logic                 err;
  } done_t;

  done_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    wr_cnt[NP] = '{default: 0};

  always @(posedge clk)
    for (int i = 0; i < NP; i++)
      if (mem_wr_valid[i] && mem_wr_ready[i]) wr_cnt[i]++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [NP-1:0] m, input logic [ADDR_WIDTH-1:0] a,
                      input logic [DATA_WIDTH-1:0] d, input logic [TAG_WIDTH-1:0] t,
                      input logic [PB-1:0] s, input logic err);
    check("send.ready", 64'(mc_req_ready), 64'd1);
    mc_req_mask     = m;
    mc_req_addr     = a;
    mc_req_data     = d;
    mc_req_tag      = t;
    mc_req_src_port = s;
    mc_req_valid    = 1'b1;
    exp_q.push_back('{tag: t, src: s, err: err});
    step();
    mc_req_valid = 1'b0;
  endtask

  task automatic expect_done(input string name);
    done_t e;
    check({name, ".done"}, 64'(mc_done), 64'd1);
    check({name, ".sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({name, ".tag"}, 64'(mc_done_tag), 64'(e.tag));
      check({name, ".src"}, 64'(mc_done_src_port), 64'(e.src));
      check({name, ".err"}, 64'(mc_error), 64'(e.err));
    end
  endtask

  // Accept, all ports ready at once, every member acks in the following cycle.
  task automatic simple_write(input string name, input logic [NP-1:0] m,
                              input logic [TAG_WIDTH-1:0] t, input logic [PB-1:0] s);
    mem_wr_ready = '1;
    send(m, ADDR_WIDTH'(16'h0500), 32'h0F0F_0F0F, t, s, 1'b0);
    check({name, ".valid"}, 64'(mem_wr_valid), 64'(m));
    step();
    mem_wr_ack = m;
    step();
    mem_wr_ack = '0;
    expect_done(name);
    step();
    check({name, ".idle_ready"}, 64'(mc_req_ready), 64'd1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, ".valid"}, 64'(mem_wr_valid), 64'd0);
    check({name, ".done"},  64'(mc_done), 64'd0);
    check({name, ".error"}, 64'(mc_error), 64'd0);
    check({name, ".busy"},  64'(busy), 64'd0);
    check({name, ".ready"}, 64'(mc_req_ready), 64'd1);
    check({name, ".addr"},  64'(mem_wr_addr), 64'd0);
    check({name, ".data"},  64'(mem_wr_data), 64'd0);
    check({name, ".tag"},   64'(mc_done_tag), 64'd0);
    check({name, ".src"},   64'(mc_done_src_port), 64'd0);
  endtask

  initial begin
    int    base[NP];
    done_t dropped;

    rst_n           = 1'b0;
    mc_req_valid    = 1'b0;
    mc_req_mask     = '0;
    mc_req_addr     = '0;
    mc_req_data     = '0;
    mc_req_tag      = '0;
    mc_req_src_port = '0;
    mem_wr_ready    = '0;
    mem_wr_ack      = '0;
    #12;
    check_reset_values("rst");
    rst_n = 1'b1;
    step();
    check("rst.ready_after", 64'(mc_req_ready), 64'd1);

    // Single-member write
    mem_wr_ready = 4'b1111;
    send(4'b0100, ADDR_WIDTH'(16'h0040), 32'hDEAD_BEEF, 8'd5, 2'd2, 1'b0);
    check("t1.valid_t1", 64'(mem_wr_valid), 64'b0100);
    check("t1.addr", 64'(mem_wr_addr), 64'h40);
    check("t1.data", 64'(mem_wr_data), 64'hDEAD_BEEF);
    check("t1.busy", 64'(busy), 64'd1);
    check("t1.not_ready", 64'(mc_req_ready), 64'd0);
    step();
    check("t1.valid_t2", 64'(mem_wr_valid), 64'd0);
    check("t1.no_done_t2", 64'(mc_done), 64'd0);
    mem_wr_ack = 4'b0100;
    step();
    mem_wr_ack = '0;
    expect_done("t1");
    step();
    check("t1.ready_t4", 64'(mc_req_ready), 64'd1);
    check("t1.done_gone", 64'(mc_done), 64'd0);

    // Full multicast, port 3 ready three cycles late, one ack per cycle
    for (int i = 0; i < NP; i++) base[i] = wr_cnt[i];
    mem_wr_ready = 4'b0111;
    send(4'b1111, ADDR_WIDTH'(16'h0080), 32'h1234_5678, 8'd6, 2'd1, 1'b0);
    check("t2.valid_t1", 64'(mem_wr_valid), 64'b1111);
    step();
    check("t2.valid_t2", 64'(mem_wr_valid), 64'b1000);
    mem_wr_ack = 4'b0001;
    step();
    check("t2.valid_t3", 64'(mem_wr_valid), 64'b1000);
    mem_wr_ack = 4'b0010;
    step();
    check("t2.valid_t4", 64'(mem_wr_valid), 64'b1000);
    mem_wr_ready = 4'b1111;
    mem_wr_ack   = 4'b0100;
    step();
    check("t2.valid_t5", 64'(mem_wr_valid), 64'd0);
    check("t2.no_done_t5", 64'(mc_done), 64'd0);
    mem_wr_ack = 4'b1000;
    step();
    mem_wr_ack = '0;
    expect_done("t2");
    step();
    check("t2.single_done", 64'(mc_done), 64'd0);
    for (int i = 0; i < NP; i++)
      check($sformatf("t2.writes_p%0d", i), 64'(wr_cnt[i] - base[i]), 64'd1);

    // Ack in the handshake cycle is ignored; spurious non-member ack ignored
    mem_wr_ready = 4'b0001;
    send(4'b0011, ADDR_WIDTH'(16'h00C0), 32'hCAFE_F00D, 8'd7, 2'd3, 1'b0);
    check("t3.valid_t1", 64'(mem_wr_valid), 64'b0011);
    step();
    check("t3.valid_t2", 64'(mem_wr_valid), 64'b0010);
    mem_wr_ready = 4'b0011;
    mem_wr_ack   = 4'b1011;
    step();
    mem_wr_ack = '0;
    check("t3.valid_t3", 64'(mem_wr_valid), 64'd0);
    check("t3.no_done_t3", 64'(mc_done), 64'd0);
    step();
    check("t3.no_done_t4", 64'(mc_done), 64'd0);
    check("t3.busy_t4", 64'(busy), 64'd1);
    mem_wr_ack = 4'b0010;
    step();
    mem_wr_ack = '0;
    expect_done("t3");
    step();

    // Timeout: port 1 never acks; abort after TO cycles with no progress
    mem_wr_ready = 4'b1111;
    send(4'b0011, ADDR_WIDTH'(16'h0100), 32'h0BAD_F00D, 8'd8, 2'd0, 1'b1);
    step();
    mem_wr_ack = 4'b0001;
    step();
    mem_wr_ack = '0;
    for (int j = 1; j <= TO; j++) begin
      check($sformatf("t4.no_done_ack+%0d", j), 64'(mc_done), 64'd0);
      step();
    end
    expect_done("t4");
    check("t4.valid_dropped", 64'(mem_wr_valid), 64'd0);
    step();
    check("t4.ready_after", 64'(mc_req_ready), 64'd1);
    simple_write("t4.next", 4'b0001, 8'd13, 2'd1);

    // Zero mask, back-to-back every two cycles
    for (int k = 0; k < 3; k++) begin
      send(4'b0000, ADDR_WIDTH'(16'h0200 + k), DATA_WIDTH'(k), TAG_WIDTH'(9 + k), PB'(k), 1'b0);
      check($sformatf("t5.valid_%0d", k), 64'(mem_wr_valid), 64'd0);
      expect_done($sformatf("t5.%0d", k));
      step();
    end

    // Reset during WAIT_ACK abandons the request
    mem_wr_ready = 4'b1111;
    send(4'b0001, ADDR_WIDTH'(16'h0300), 32'h55AA_55AA, 8'd12, 2'd3, 1'b0);
    step();
    check("t6.busy_wait", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    dropped = exp_q.pop_back();
    check_reset_values("t6.rst");
    mem_wr_ack = 4'b0001;
    step();
    mem_wr_ack = '0;
    check("t6.no_done_rst1", 64'(mc_done), 64'd0);
    step();
    check("t6.no_done_rst2", 64'(mc_done), 64'd0);
    #2 rst_n = 1'b1;
    step();
    check("t6.no_done_after", 64'(mc_done), 64'd0);
    check("t6.ready_after", 64'(mc_req_ready), 64'd1);
    simple_write("t6.next", 4'b1000, 8'd14, 2'd1);

    check("end.sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
